inst_fetch: RTL and testbench

Consumer end of the PC-sender interface. It accepts one fetch address per cycle (pc_i qualified by pc_valid) and returns the 32-bit instruction to the IF/ID latch. Lookup goes through a direct-mapped, one-word-per-line instruction cache. On a miss, the block gathers the word byte-by-byte over the shared byte-wide memory port. It raises stall_req to freeze the PC sender while a miss is outstanding, and drops in-flight work on a branch redirect.

---
 rtl/inst_fetch.sv | 130 +++++++++++++
 tb/tb_inst_fetch.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch: direct-mapped one-word-per-line I-cache with byte-serial miss refill.
// Handshake: a fetch is taken when pc_valid=1 in IDLE with br=0; misses hold stall_req until the line is filled.
module inst_fetch #(
  parameter int ADDR_W  = 18,
  parameter int INDEX_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       pc_i,
  input  logic              pc_valid,
  input  logic              br,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              stall_req,
  output logic [31:0]       inst_o,
  output logic [31:0]       pc_o,
  output logic              inst_valid,
  output logic [1:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE = 2'd0, MISS = 2'd1, DONE = 2'd2} state_t;

  state_t             state;
  logic [31:0]        data_mem [LINES];
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [LINES-1:0]   valid_mem;

  logic [31:0]        req_pc;
  logic [2:0]         issue_cnt;
  logic [1:0]         recv_cnt;
  logic [23:0]        asm_q;

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               hit;
  logic               last_byte;
  logic [31:0]        fill_word;

  assign pc_index  = pc_i[INDEX_W+1:2];
  assign pc_tag    = pc_i[ADDR_W-1:INDEX_W+2];
  assign req_index = req_pc[INDEX_W+1:2];
  assign req_tag   = req_pc[ADDR_W-1:INDEX_W+2];
  assign hit       = valid_mem[pc_index] && (tag_mem[pc_index] == pc_tag);
  assign last_byte = (state == MISS) && mem_rvalid && (recv_cnt == 2'd3);
  // The final byte is taken straight off the bus, so only three bytes need holding.
  assign fill_word = {mem_rdata, asm_q};

  assign mem_req   = (state == MISS) && (issue_cnt < 3'd4);
  assign mem_addr  = mem_req ? ({req_pc[ADDR_W-1:2], 2'b00} + ADDR_W'(issue_cnt)) : '0;
  assign dbg_state = state;

  // Line payload is not reset; only the valid bits gate its use.
  always_ff @(posedge clock) begin
    if (!reset && last_byte) begin
      data_mem[req_index] <= fill_word;
      tag_mem[req_index]  <= req_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid_mem  <= '0;
      req_pc     <= '0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
      asm_q      <= '0;
      stall_req  <= 1'b0;
      inst_o     <= '0;
      pc_o       <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      // A completed line is still correct under a redirect, so it is kept.
      if (last_byte) valid_mem[req_index] <= 1'b1;
      if (br) begin
        state     <= IDLE;
        stall_req <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pc_valid) begin
              if (hit) begin
                inst_o     <= data_mem[pc_index];
                pc_o       <= pc_i;
                inst_valid <= 1'b1;
              end else begin
                req_pc    <= pc_i;
                issue_cnt <= '0;
                recv_cnt  <= '0;
                state     <= MISS;
                stall_req <= 1'b1;
              end
            end
          end
          MISS: begin
            if (mem_req && mem_gnt) issue_cnt <= issue_cnt + 3'd1;
            if (mem_rvalid) begin
              case (recv_cnt)
                2'd0:    asm_q[7:0]   <= mem_rdata;
                2'd1:    asm_q[15:8]  <= mem_rdata;
                2'd2:    asm_q[23:16] <= mem_rdata;
                default: ;
              endcase
              recv_cnt <= recv_cnt + 2'd1;
            end
            if (last_byte) begin
              inst_o     <= fill_word;
              pc_o       <= req_pc;
              inst_valid <= 1'b1;
              state      <= DONE;
              stall_req  <= 1'b0;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table of fetches (hit/miss) plus hand-written miss, flush and reset sequences.
module tb_inst_fetch;

  localparam int ADDR_W  = 18;
  localparam int INDEX_W = 7;

  logic              clock;
  logic              reset;
  logic [31:0]       pc_i;
  logic              pc_valid;
  logic              br;
  logic              mem_gnt;
  logic [7:0]        mem_rdata;
  logic              mem_rvalid;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              stall_req;
  logic [31:0]       inst_o;
  logic [31:0]       pc_o;
  logic              inst_valid;
  logic [1:0]        dbg_state;

  int passed = 0;
  int total  = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic              gnt_pat[$];

  typedef struct {
    logic [31:0] pc;
    logic        miss;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[8];

  inst_fetch #(.ADDR_W(ADDR_W), .INDEX_W(INDEX_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_i       (pc_i),
    .pc_valid   (pc_valid),
    .br         (br),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .stall_req  (stall_req),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .inst_valid (inst_valid),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [ADDR_W-1:0] a);
    case (a)
      18'h10:  return 8'h13;
      18'h11:  return 8'h05;
      18'h12:  return 8'h10;
      18'h13:  return 8'h00;
      default: return (a[7:0] * 8'd29) ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [ADDR_W-1:0] b;
    b = {pc[ADDR_W-1:2], 2'b00};
    return {mem_byte(b + 18'd3), mem_byte(b + 18'd2), mem_byte(b + 18'd1), mem_byte(b)};
  endfunction

  // Byte memory: a granted request returns its byte during the following cycle.
  initial begin : responder
    logic              g;
    logic [ADDR_W-1:0] a;
    mem_rvalid = 1'b0;
    mem_rdata  = 8'h00;
    forever begin
      @(posedge clock);
      g = mem_req && mem_gnt && !reset;
      a = mem_addr;
      @(negedge clock);
      mem_rvalid = g;
      mem_rdata  = g ? mem_byte(a) : 8'h00;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // driver: fetch expected to hit
  task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] word, input string tag);
    @(negedge clock);
    pc_i = pc;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'd1);
    chk({tag, " inst_o"}, inst_o, word);
    chk({tag, " pc_o"}, pc_o, pc);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, " stall_req"}, 32'(stall_req), 32'd0);
  endtask

  // driver: fetch expected to miss; grant per cycle from gnt_pat (default 1)
  task automatic run_miss(input logic [31:0] pc, input logic [31:0] word, input int exp_lat,
                          input string tag);
    int                lat;
    int                stall_cyc;
    bit                seen;
    logic [ADDR_W-1:0] base;
    base = {pc[ADDR_W-1:2], 2'b00};
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(base + 18'(k));
    @(negedge clock);
    pc_i = pc;
    pc_valid = 1'b1;
    mem_gnt = 1'b1;
    seen = 0;
    lat = 0;
    stall_cyc = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clock);
      pc_valid = 1'b0;
      if (inst_valid) begin
        seen = 1;
        lat = i - 1;
      end else begin
        if (stall_req) stall_cyc++;
        mem_gnt = (gnt_pat.size() > 0) ? gnt_pat.pop_front() : 1'b1;
        if (mem_req && mem_gnt) begin
          if (exp_q.size() == 0) chk({tag, " extra issue"}, 32'(mem_addr), 32'hFFFF_FFFF);
          else chk({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_q.pop_front()));
        end
      end
    end
    chk({tag, " completed"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " stall cycles"}, 32'(stall_cyc), 32'(exp_lat));
    chk({tag, " bytes left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " inst_o"}, inst_o, word);
    chk({tag, " pc_o"}, pc_o, pc);
    chk({tag, " stall in DONE"}, 32'(stall_req), 32'd0);
    chk({tag, " mem_req in DONE"}, 32'(mem_req), 32'd0);
    chk({tag, " state DONE"}, 32'(dbg_state), 32'd2);
    mem_gnt = 1'b1;
    gnt_pat.delete();
    exp_q.delete();
  endtask

  initial begin : main
    bit seen;
    reset = 1'b1;
    pc_i = 32'h0;
    pc_valid = 1'b0;
    br = 1'b0;
    mem_gnt = 1'b1;

    vecs[0] = '{32'h0000_0010, 1'b1, 32'h0010_0513};
    vecs[1] = '{32'h0000_0010, 1'b0, 32'h0010_0513};
    vecs[2] = '{32'h0000_0000, 1'b1, exp_word(32'h0)};
    vecs[3] = '{32'h0000_0004, 1'b1, exp_word(32'h4)};
    vecs[4] = '{32'h0000_0008, 1'b1, exp_word(32'h8)};
    vecs[5] = '{32'h0000_0210, 1'b1, exp_word(32'h210)};
    vecs[6] = '{32'h0000_0010, 1'b1, 32'h0010_0513};
    vecs[7] = '{32'h0000_0004, 1'b0, exp_word(32'h4)};

    repeat (3) @(negedge clock);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset stall_req", 32'(stall_req), 32'd0);
    chk("reset inst_o", inst_o, 32'd0);
    chk("reset pc_o", pc_o, 32'd0);
    chk("reset inst_valid", 32'(inst_valid), 32'd0);
    chk("reset state", 32'(dbg_state), 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].miss) run_miss(vecs[v].pc, vecs[v].word, 5, $sformatf("vec%0d", v));
      else hit_fetch(vecs[v].pc, vecs[v].word, $sformatf("vec%0d", v));
    end

    // back-to-back hits on 0x0, 0x4, 0x8
    @(negedge clock);
    pc_i = 32'h0;
    pc_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (k < 2) pc_i = 32'(4 * (k + 1));
      else pc_valid = 1'b0;
      chk($sformatf("b2b%0d inst_valid", k), 32'(inst_valid), 32'd1);
      chk($sformatf("b2b%0d pc_o", k), pc_o, 32'(4 * k));
      chk($sformatf("b2b%0d inst_o", k), inst_o, exp_word(32'(4 * k)));
    end
    @(negedge clock);
    chk("b2b pulse ends", 32'(inst_valid), 32'd0);

    // grant gaps, then a pc_valid in DONE must be dropped
    gnt_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    run_miss(32'h100, exp_word(32'h100), 8, "gaps");
    pc_i = 32'h300;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    chk("done drop inst_valid", 32'(inst_valid), 32'd0);
    chk("done drop mem_req", 32'(mem_req), 32'd0);
    chk("done drop stall", 32'(stall_req), 32'd0);
    chk("done drop state", 32'(dbg_state), 32'd0);
    hit_fetch(32'h100, exp_word(32'h100), "gaps hit");

    // flush after two bytes of a miss at 0x40
    @(negedge clock);
    pc_i = 32'h40;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    repeat (2) @(negedge clock);
    br = 1'b1;
    @(negedge clock);
    br = 1'b0;
    chk("flush mem_req", 32'(mem_req), 32'd0);
    chk("flush stall", 32'(stall_req), 32'd0);
    chk("flush inst_valid", 32'(inst_valid), 32'd0);
    chk("flush state", 32'(dbg_state), 32'd0);
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (inst_valid || mem_req) seen = 1;
    end
    chk("flush quiet", 32'(seen), 32'd0);
    run_miss(32'h40, exp_word(32'h40), 5, "refetch");

    // br together with the 4th byte: no output, but the line is filled
    @(negedge clock);
    pc_i = 32'h80;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    repeat (4) @(negedge clock);
    br = 1'b1;
    @(negedge clock);
    br = 1'b0;
    chk("br4 inst_valid", 32'(inst_valid), 32'd0);
    chk("br4 stall", 32'(stall_req), 32'd0);
    chk("br4 state", 32'(dbg_state), 32'd0);
    hit_fetch(32'h80, exp_word(32'h80), "br4 hit");

    // reset in the middle of a miss invalidates the whole cache
    @(negedge clock);
    pc_i = 32'h500;
    pc_valid = 1'b1;
    @(negedge clock);
    pc_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst mid mem_req", 32'(mem_req), 32'd0);
    chk("rst mid stall", 32'(stall_req), 32'd0);
    chk("rst mid inst_valid", 32'(inst_valid), 32'd0);
    chk("rst mid state", 32'(dbg_state), 32'd0);
    run_miss(32'h0, exp_word(32'h0), 5, "post reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
